// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issue path: instruction field
// positions, opcode constants, issue FSM states and immediate helpers.
package cpu_pkg;

  // Instruction field bit positions within the 16-bit word
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int OP_HI   = 12;
  localparam int OP_LO   = 11;
  localparam int RN_HI   = 10;
  localparam int RN_LO   = 8;
  localparam int RD_HI   = 7;
  localparam int RD_LO   = 5;
  localparam int SH_HI   = 4;
  localparam int SH_LO   = 3;
  localparam int RM_HI   = 2;
  localparam int RM_LO   = 0;
  localparam int IMM8_HI = 7;
  localparam int IMM8_LO = 0;
  localparam int IMM5_HI = 4;
  localparam int IMM5_LO = 0;

  // Opcode constants
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Issue FSM states
  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_READY = 3'd1,
    S_START = 3'd2,
    S_ACK   = 3'd3,
    S_EXEC  = 3'd4
  } issue_state_t;

  // Sign-extend an 8-bit immediate to 16 bits
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  // Sign-extend a 5-bit immediate to 16 bits
  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular-buffer FIFO for instruction words. Pop on empty and push on
// full are ignored; the head is read from storage, so there is no bypass.
module instr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next pointer and occupancy values; pointers wrap since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue stage: buffers instructions, holds the active one in
// the IR, decodes its fields and handshakes with the controller through
// start / waiting, re-issuing if the controller never leaves its wait state.
module instr_issue
  import cpu_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int ACK_TIMEOUT = 4,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int TW          = $clog2(ACK_TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  input  logic          waiting,
  output logic          start,
  output logic [2:0]    opcode,
  output logic [1:0]    ALU_op,
  output logic [1:0]    shift_op,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [2:0]    rm,
  output logic [15:0]   sximm8,
  output logic [15:0]   sximm5,
  output logic          ir_valid,
  output logic [CW-1:0] count
);

  issue_state_t  state_q, state_d;
  logic [15:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          start_q;
  logic          pop_s;
  logic          push_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [15:0]   fifo_dout_s;

  assign in_ready = ~fifo_full_s;
  assign push_s   = in_valid & in_ready;

  instr_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (in_instr),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count)
  );

  // Next-state logic: IR loads, ir_valid tracking and the acknowledge timeout
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    tmo_d      = tmo_q;
    pop_s      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          ir_d       = fifo_dout_s;
          ir_valid_d = 1'b1;
          state_d    = S_READY;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_READY: begin
        if (waiting) begin
          state_d = S_START;
        end else begin
          state_d = S_READY;
        end
      end
      S_START: begin
        tmo_d   = TW'(0);
        state_d = S_ACK;
      end
      S_ACK: begin
        // Counting the start cycle and the re-issue cycle, the retry pulse
        // lands ACK_TIMEOUT + 1 cycles after the original one.
        if (!waiting) begin
          state_d = S_EXEC;
        end else if ((int'(tmo_q) + 2) >= ACK_TIMEOUT) begin
          state_d = S_READY;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (waiting) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            ir_d    = fifo_dout_s;
            state_d = S_READY;
          end else begin
            ir_valid_d = 1'b0;
            state_d    = S_EMPTY;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // State, IR, timeout and registered start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      tmo_q      <= TW'(0);
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      tmo_q      <= tmo_d;
      start_q    <= (state_d == S_START);
    end
  end

  assign start    = start_q;
  assign ir_valid = ir_valid_q;
  assign opcode   = ir_q[OPC_HI:OPC_LO];
  assign ALU_op   = ir_q[OP_HI:OP_LO];
  assign shift_op = ir_q[SH_HI:SH_LO];
  assign rn       = ir_q[RN_HI:RN_LO];
  assign rd       = ir_q[RD_HI:RD_LO];
  assign rm       = ir_q[RM_HI:RM_LO];
  assign sximm8   = sext8(ir_q[IMM8_HI:IMM8_LO]);
  assign sximm5   = sext5(ir_q[IMM5_HI:IMM5_LO]);

endmodule
